// File: rtl/async_mem_wb_burst_bridge_if.sv
// async_mem_wb_burst_bridge_if
// Wishbone classic bus bundle between the async-memory bridge and a Wishbone slave.
// Signal names keep the bridge's point of view (_o = driven by the bridge).
//   master modport: adr/dat/sel/we/cyc/stb out, dat_i/ack_i/err_i in (bridge side)
//   slave modport : the mirror image (slave or testbench side)
interface async_mem_wb_burst_bridge_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_we_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/async_mem_wb_burst_bridge.sv
// async_mem_wb_burst_bridge
// Bridges an asynchronous SRAM-style host port onto a Wishbone classic master.
// Host writes are posted through a small FIFO and issued as back-to-back Wishbone
// writes; host reads stall the host (am_wait_n low) until all posted writes have
// drained and the Wishbone read has returned.
// Ports:
//   wb_clk_i, wb_rst_i        : sole clock, synchronous active-high reset
//   am_addr/am_data_i/am_be_n : host address, write data, active-low byte enables
//   am_cs_n/am_we_n/am_oe_n   : host strobes (asynchronous, synchronized here)
//   am_data_o/am_data_oe      : read data and its drive enable
//   am_wait_n                 : low = host must hold its strobe
//   wb                        : Wishbone master bus (interface, master modport)
//   wr_ovf_o                  : sticky, set when a posted write was dropped
//   err_cnt_o                 : saturating count of Wishbone error terminations
module async_mem_wb_burst_bridge #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned WF_DEPTH = 4
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [AW-1:0]              am_addr,
    input  logic [DW-1:0]              am_data_i,
    input  logic [DW/8-1:0]            am_be_n,
    input  logic                       am_cs_n,
    input  logic                       am_we_n,
    input  logic                       am_oe_n,
    output logic [DW-1:0]              am_data_o,
    output logic                       am_data_oe,
    output logic                       am_wait_n,
    async_mem_wb_burst_bridge_if.master wb,
    output logic                       wr_ovf_o,
    output logic [7:0]                 err_cnt_o
);
    localparam int unsigned SW = DW / 8;
    localparam int unsigned PW = (WF_DEPTH > 1) ? $clog2(WF_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(WF_DEPTH);
    localparam logic [CW-1:0] WaitCnt = CW'(WF_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StRdHold} state_e;

    state_e state_q, state_d;

    // Strobe synchronizers: s1 = first flop, s2 = second flop, s3 = previous s2 sample.
    logic cs_s1_q, cs_s1_d, we_s1_q, we_s1_d, oe_s1_q, oe_s1_d;
    logic cs_s2_q, cs_s2_d, we_s2_q, we_s2_d, oe_s2_q, oe_s2_d;
    logic cs_s3_q, cs_s3_d, we_s3_q, we_s3_d, oe_s3_q, oe_s3_d;
    logic [AW-1:0] addr_s2_q, addr_s2_d, addr_s3_q, addr_s3_d;
    logic [DW-1:0] data_s2_q, data_s2_d, data_s3_q, data_s3_d;
    logic [SW-1:0] be_s2_q, be_s2_d, be_s3_q, be_s3_d;

    // Posted-write FIFO; storage is not reset, the pointers/count define validity.
    logic [AW-1:0] wf_adr_q [WF_DEPTH];
    logic [DW-1:0] wf_dat_q [WF_DEPTH];
    logic [SW-1:0] wf_sel_q [WF_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          rd_pend_q, rd_pend_d;
    logic [AW-1:0] rd_adr_q, rd_adr_d;
    logic [SW-1:0] rd_sel_q, rd_sel_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic wr_det, rd_det, bus_act, ack, err, push, pop;

    // Write ends on the strobe's rising edge; the chip select must have been low with it.
    assign wr_det  = we_s2_q & ~we_s3_q & ~cs_s3_q;
    assign rd_det  = ~cs_s2_q & ~oe_s2_q & (cs_s3_q | oe_s3_q);
    assign bus_act = (state_q == StWr) || (state_q == StRd);
    // Terminations are only honoured while a cycle is actually strobed.
    assign ack     = bus_act & wb.wb_ack_i;
    assign err     = bus_act & wb.wb_err_i;
    assign push    = wr_det & (cnt_q != FullCnt);
    assign pop     = (state_q == StWr) & (ack | err);

    always_comb begin
        cs_s1_d   = am_cs_n;
        we_s1_d   = am_we_n;
        oe_s1_d   = am_oe_n;
        cs_s2_d   = cs_s1_q;
        we_s2_d   = we_s1_q;
        oe_s2_d   = oe_s1_q;
        addr_s2_d = am_addr;
        data_s2_d = am_data_i;
        be_s2_d   = am_be_n;
        cs_s3_d   = cs_s2_q;
        we_s3_d   = we_s2_q;
        oe_s3_d   = oe_s2_q;
        addr_s3_d = addr_s2_q;
        data_s3_d = data_s2_q;
        be_s3_d   = be_s2_q;

        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        ovf_d     = ovf_q | (wr_det & (cnt_q == FullCnt));
        err_cnt_d = (err && (err_cnt_q != 8'hff)) ? err_cnt_q + 8'd1 : err_cnt_q;

        rd_pend_d = rd_pend_q;
        rd_adr_d  = rd_adr_q;
        rd_sel_d  = rd_sel_q;
        if (rd_det && !rd_pend_q) begin
            rd_pend_d = 1'b1;
            rd_adr_d  = addr_s2_q;
            rd_sel_d  = ~be_s2_q;
        end

        rdata_d = rdata_q;
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // Posted writes always drain before a read is allowed onto the bus.
                if (cnt_q != '0) begin
                    state_d = StWr;
                end else if (rd_pend_q) begin
                    state_d = StRd;
                end
            end
            StWr: begin
                if (pop && (cnt_d == '0)) begin
                    state_d = StIdle;
                end
            end
            StRd: begin
                if (ack) begin
                    rdata_d   = wb.wb_dat_i;
                    rd_pend_d = 1'b0;
                    state_d   = StRdHold;
                end else if (err) begin
                    rdata_d   = '1;
                    rd_pend_d = 1'b0;
                    state_d   = StRdHold;
                end
            end
            StRdHold: begin
                if (oe_s2_q || cs_s2_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            cs_s1_q   <= 1'b1;
            we_s1_q   <= 1'b1;
            oe_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            we_s2_q   <= 1'b1;
            oe_s2_q   <= 1'b1;
            cs_s3_q   <= 1'b1;
            we_s3_q   <= 1'b1;
            oe_s3_q   <= 1'b1;
            addr_s2_q <= '0;
            data_s2_q <= '0;
            be_s2_q   <= '1;
            addr_s3_q <= '0;
            data_s3_q <= '0;
            be_s3_q   <= '1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_adr_q  <= '0;
            rd_sel_q  <= '0;
            rdata_q   <= '0;
            ovf_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cs_s1_q   <= cs_s1_d;
            we_s1_q   <= we_s1_d;
            oe_s1_q   <= oe_s1_d;
            cs_s2_q   <= cs_s2_d;
            we_s2_q   <= we_s2_d;
            oe_s2_q   <= oe_s2_d;
            cs_s3_q   <= cs_s3_d;
            we_s3_q   <= we_s3_d;
            oe_s3_q   <= oe_s3_d;
            addr_s2_q <= addr_s2_d;
            data_s2_q <= data_s2_d;
            be_s2_q   <= be_s2_d;
            addr_s3_q <= addr_s3_d;
            data_s3_q <= data_s3_d;
            be_s3_q   <= be_s3_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_adr_q  <= rd_adr_d;
            rd_sel_q  <= rd_sel_d;
            rdata_q   <= rdata_d;
            ovf_q     <= ovf_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            wf_adr_q[wr_ptr_q] <= addr_s3_q;
            wf_dat_q[wr_ptr_q] <= data_s3_q;
            wf_sel_q[wr_ptr_q] <= ~be_s3_q;
        end
    end

    assign wb.wb_cyc_o = bus_act;
    assign wb.wb_stb_o = bus_act;
    assign wb.wb_we_o  = (state_q == StWr);
    assign wb.wb_adr_o = (state_q == StWr) ? wf_adr_q[rd_ptr_q] : rd_adr_q;
    assign wb.wb_dat_o = (state_q == StWr) ? wf_dat_q[rd_ptr_q] : '0;
    assign wb.wb_sel_o = (state_q == StWr) ? wf_sel_q[rd_ptr_q] : rd_sel_q;

    assign am_data_o  = rdata_q;
    assign am_data_oe = (state_q == StRdHold);
    // Stall when the FIFO is nearly full or while a read is outstanding.
    assign am_wait_n  = (state_q == StRdHold) | (~rd_pend_q & (cnt_q < WaitCnt));
    assign wr_ovf_o   = ovf_q;
    assign err_cnt_o  = err_cnt_q;
endmodule

// File: tb/tb_async_mem_wb_burst_bridge.sv
// Self-checking bench for async_mem_wb_burst_bridge: a host-side driver, a Wishbone
// slave with a memory, and a transaction-level reference (ordered op log + memory).
module tb_async_mem_wb_burst_bridge;
    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned WF_DEPTH = 4;
    localparam logic [31:0] A        = 32'h8300_0000;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] am_addr, am_data_i, am_data_o;
    logic [3:0]  am_be_n;
    logic        am_cs_n, am_we_n, am_oe_n, am_data_oe, am_wait_n, wr_ovf_o;
    logic [7:0]  err_cnt_o;

    logic        slv_ack, slv_err, stray_ack, stray_err, hold, err_next;
    logic [31:0] slv_dat;
    int          ack_dly, dly_cnt;
    int          n_checks, n_fail, exp_err;

    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    txn_t        exp_log [$];
    txn_t        obs_log [$];

    always #5 clk = ~clk;

    async_mem_wb_burst_bridge_if #(.AW(AW), .DW(DW)) bus ();

    assign bus.wb_dat_i = slv_dat;
    assign bus.wb_ack_i = slv_ack | stray_ack;
    assign bus.wb_err_i = slv_err | stray_err;

    async_mem_wb_burst_bridge #(.AW(AW), .DW(DW), .WF_DEPTH(WF_DEPTH)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .am_addr   (am_addr),
        .am_data_i (am_data_i),
        .am_be_n   (am_be_n),
        .am_cs_n   (am_cs_n),
        .am_we_n   (am_we_n),
        .am_oe_n   (am_oe_n),
        .am_data_o (am_data_o),
        .am_data_oe(am_data_oe),
        .am_wait_n (am_wait_n),
        .wb        (bus),
        .wr_ovf_o  (wr_ovf_o),
        .err_cnt_o (err_cnt_o)
    );

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hc3a5_0f1e;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic txn_t mk_txn(input logic we, input logic [31:0] adr,
                                    input logic [31:0] dat, input logic [3:0] sel);
        txn_t t;
        t.we = we; t.adr = adr; t.dat = dat; t.sel = sel;
        return t;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Wishbone slave: responds after ack_dly strobed cycles unless held off.
    initial begin
        slv_ack = 1'b0; slv_err = 1'b0; slv_dat = '0; dly_cnt = 0;
        forever begin
            @(negedge clk);
            slv_ack = 1'b0;
            slv_err = 1'b0;
            if (bus.wb_cyc_o && bus.wb_stb_o && !hold) begin
                if (dly_cnt < ack_dly) begin
                    dly_cnt++;
                end else begin
                    dly_cnt = 0;
                    if (err_next) begin
                        slv_err  = 1'b1;
                        err_next = 1'b0;
                    end else begin
                        slv_ack = 1'b1;
                    end
                    if (bus.wb_we_o) begin
                        if (slv_ack) begin
                            slv_mem[bus.wb_adr_o] = merge(slv_rd(bus.wb_adr_o), bus.wb_dat_o,
                                                          bus.wb_sel_o);
                        end
                        obs_log.push_back(mk_txn(1'b1, bus.wb_adr_o, bus.wb_dat_o,
                                                 bus.wb_sel_o));
                    end else begin
                        slv_dat = slv_ack ? slv_rd(bus.wb_adr_o) : $urandom;
                        obs_log.push_back(mk_txn(1'b0, bus.wb_adr_o, 32'h0, 4'h0));
                    end
                end
            end else begin
                dly_cnt = 0;
            end
        end
    end

    task automatic host_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] be_n, input bit respect_wait, input bit accept);
        int n;
        n = 0;
        if (respect_wait) begin
            while (!am_wait_n && n < 500) begin
                @(negedge clk);
                n++;
            end
            check_val("wr_wait_n", am_wait_n, 1);
        end
        @(negedge clk);
        am_addr = addr; am_data_i = data; am_be_n = be_n;
        am_cs_n = 1'b0; am_we_n = 1'b0;
        repeat (3) @(negedge clk);
        am_we_n = 1'b1;
        repeat (3) @(negedge clk);
        am_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        if (accept) begin
            exp_log.push_back(mk_txn(1'b1, addr, data, ~be_n));
            ref_mem[addr] = merge(ref_rd(addr), data, ~be_n);
        end
    endtask

    task automatic host_read(input logic [31:0] addr, output logic [31:0] data,
                             output logic wait_seen);
        int n;
        n = 0;
        @(negedge clk);
        am_addr = addr; am_be_n = 4'h0;
        am_cs_n = 1'b0; am_oe_n = 1'b0;
        repeat (4) @(negedge clk);
        wait_seen = am_wait_n;
        while (!am_data_oe && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("rd_oe_rise", am_data_oe, 1);
        data = am_data_o;
        check_val("rd_hold_wait_n", am_wait_n, 1);
        exp_log.push_back(mk_txn(1'b0, addr, 32'h0, 4'h0));
        am_oe_n = 1'b1;
        @(negedge clk);
        check_val("rd_oe_held", am_data_oe, 1);
        am_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rd_oe_fall", am_data_oe, 0);
    endtask

    task automatic wait_idle();
        int quiet, n;
        quiet = 0; n = 0;
        while (quiet < 3 && n < 2000) begin
            @(negedge clk);
            n++;
            if (!bus.wb_cyc_o) quiet++;
            else quiet = 0;
        end
        check_val("idle_cyc", bus.wb_cyc_o, 0);
    endtask

    task automatic compare_log(input string tag);
        txn_t e, o;
        check_val({tag, "_len"}, obs_log.size(), exp_log.size());
        while (exp_log.size() > 0 && obs_log.size() > 0) begin
            e = exp_log.pop_front();
            o = obs_log.pop_front();
            check_val({tag, "_we"}, o.we, e.we);
            check_val({tag, "_adr"}, o.adr, e.adr);
            if (e.we) begin
                check_val({tag, "_dat"}, o.dat, e.dat);
                check_val({tag, "_sel"}, o.sel, e.sel);
            end
        end
        exp_log.delete();
        obs_log.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_cyc"}, bus.wb_cyc_o, 0);
        check_val({tag, "_stb"}, bus.wb_stb_o, 0);
        check_val({tag, "_we"}, bus.wb_we_o, 0);
        check_val({tag, "_data_oe"}, am_data_oe, 0);
        check_val({tag, "_wait_n"}, am_wait_n, 1);
        check_val({tag, "_data_o"}, am_data_o, 0);
        check_val({tag, "_ovf"}, wr_ovf_o, 0);
        check_val({tag, "_err_cnt"}, err_cnt_o, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, rd;
        logic        ws;
        int          n, drops;

        n_checks = 0; n_fail = 0; exp_err = 0;
        hold = 1'b0; err_next = 1'b0; ack_dly = 0;
        stray_ack = 1'b0; stray_err = 1'b0;
        am_addr = '0; am_data_i = '0; am_be_n = 4'hf;
        am_cs_n = 1'b1; am_we_n = 1'b1; am_oe_n = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single full-word write.
        host_write(A, 32'habbabeef, 4'b0000, 1'b1, 1'b1);
        wait_idle();
        compare_log("single_wr");

        // Read back with a slow slave: host must be stalled until the ack.
        ack_dly = 6;
        host_read(A, rd, ws);
        check_val("rd_wait_low", ws, 0);
        check_val("rd_data", rd, ref_rd(A));
        wait_idle();
        compare_log("single_rd");

        // Three posted writes with the slave held off, then a back-to-back burst.
        hold = 1'b1; ack_dly = 0;
        host_write(A, 32'habbabeef, 4'b0000, 1'b1, 1'b1);
        host_write(A, 32'h55555555, 4'b0000, 1'b1, 1'b1);
        host_write(A, 32'haaaaaaaa, 4'b0000, 1'b1, 1'b1);
        check_val("b3_wait_n", am_wait_n, 0);
        check_val("b3_cyc", bus.wb_cyc_o, 1);
        check_val("b3_head_dat", bus.wb_dat_o, 32'habbabeef);
        drops = 0; n = 0;
        hold = 1'b0;
        while (obs_log.size() < 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (obs_log.size() < 3 && !bus.wb_cyc_o) drops++;
        end
        check_val("b3_cyc_drops", drops, 0);
        wait_idle();
        compare_log("burst3");

        // Write then immediate read, slow slave: the write must finish first.
        ack_dly = 5;
        host_write(A + 32'h8, 32'h1234_5678, 4'b0000, 1'b1, 1'b1);
        host_read(A + 32'h8, rd, ws);
        check_val("wr_rd_data", rd, ref_rd(A + 32'h8));
        wait_idle();
        compare_log("wr_then_rd");

        // Overflow: one more write than the FIFO holds, stall ignored.
        hold = 1'b1; ack_dly = 0;
        for (int i = 0; i < WF_DEPTH; i++) begin
            d = $urandom;
            host_write(A + 32'(i * 4), d, 4'b0000, 1'b0, 1'b1);
        end
        check_val("ovf_before", wr_ovf_o, 0);
        host_write(A + 32'(WF_DEPTH * 4), 32'hdead_0001, 4'b0000, 1'b0, 1'b0);
        check_val("ovf_flag", wr_ovf_o, 1);
        hold = 1'b0;
        wait_idle();
        compare_log("ovf");
        check_val("ovf_sticky", wr_ovf_o, 1);

        // Error-terminated read.
        err_next = 1'b1; ack_dly = 2;
        host_read(A, rd, ws);
        exp_err++;
        check_val("err_rd_data", rd, 32'hffff_ffff);
        check_val("err_cnt", err_cnt_o, exp_err);
        wait_idle();
        compare_log("err_rd");

        // Stray terminations with no strobe must be ignored.
        @(negedge clk);
        stray_ack = 1'b1; stray_err = 1'b1;
        repeat (2) @(negedge clk);
        stray_ack = 1'b0; stray_err = 1'b0;
        @(negedge clk);
        check_val("stray_err_cnt", err_cnt_o, exp_err);
        check_val("stray_cyc", bus.wb_cyc_o, 0);
        check_val("stray_oe", am_data_oe, 0);

        // Randomized mix of writes and reads against the reference memory.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] ra;
            logic [3:0]  be;
            ack_dly = $urandom_range(0, 4);
            ra = A + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 9) < 6) begin
                be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                host_write(ra, $urandom, be, 1'b1, 1'b1);
            end else begin
                host_read(ra, rd, ws);
                check_val("rand_rd_data", rd, ref_rd(ra));
            end
        end
        wait_idle();
        compare_log("rand");

        // Reset in the middle of a stalled write burst discards the queue.
        hold = 1'b1; ack_dly = 0;
        host_write(A + 32'h40, 32'h0bad_f00d, 4'b0000, 1'b1, 1'b0);
        host_write(A + 32'h44, 32'h0bad_f00e, 4'b0000, 1'b1, 1'b0);
        check_val("pre_rst_cyc", bus.wb_cyc_o, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_rst");
        rst = 1'b0;
        exp_err = 0;
        hold = 1'b0;
        repeat (20) @(negedge clk);
        check_val("rst_discard", obs_log.size(), 0);
        host_read(A + 32'h40, rd, ws);
        check_val("post_rst_rd", rd, ref_rd(A + 32'h40));
        wait_idle();
        compare_log("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/async_mem_wb_burst_bridge.md
ASYNC_MEM_WB_BURST_BRIDGE -- requirements
Module: async_mem_wb_burst_bridge

Interface
REQ-001 SHALL have parameter AW, default 32: async-side and Wishbone address width.
REQ-002 SHALL have parameter DW, default 32: data width; must be a multiple of 8; SW = DW/8.
REQ-003 SHALL have parameter WF_DEPTH, default 4: posted-write FIFO depth; power of 2, at least 2.
REQ-004 SHALL have port wb_clk_i, in, 1: sole clock.
REQ-005 SHALL have port wb_rst_i, in, 1: reset, synchronous and active-high.
REQ-006 SHALL have async-side inputs: am_addr AW, am_data_i DW, am_be_n SW (active low; all-zero = all bytes), am_cs_n 1, am_we_n 1, am_oe_n 1.
REQ-007 SHALL have async-side outputs: am_data_o DW, am_data_oe 1 (read data drive enable), am_wait_n 1 (low = host must hold strobe).
REQ-008 SHALL have Wishbone master ports: wb_adr_o AW out, wb_dat_o DW out, wb_sel_o SW out, wb_we_o out, wb_cyc_o out, wb_stb_o out, wb_dat_i DW in, wb_ack_i in, wb_err_i in.
REQ-009 SHALL have status outputs: wr_ovf_o 1 (sticky write-overflow), err_cnt_o 8 (saturating Wishbone error count).

Function
REQ-010 SHALL pass am_cs_n, am_we_n, am_oe_n through two wb_clk_i flops before use; am_addr, am_data_i, am_be_n SHALL be registered in the same stage as the second control flop.
REQ-011 SHALL detect a write as a synchronized am_we_n 0->1 transition with synchronized am_cs_n low; the address/data/byte-enables from the previous sample SHALL be pushed into the FIFO on the next cycle, with wb_sel_o = ~am_be_n.
REQ-012 SHALL drive am_wait_n low whenever FIFO occupancy >= WF_DEPTH-1 or a read is pending and not yet returned; high otherwise.
REQ-013 On a push while the FIFO is full, the entry SHALL be dropped and wr_ovf_o set; wr_ovf_o SHALL clear only on reset.
REQ-014 SHALL detect a read as synchronized am_cs_n and am_oe_n both low, rising from not-both-low; a read SHALL be serviced only after the FIFO is empty (strict ordering).
REQ-015 SHALL use FSM states IDLE, WR, RD, RD_HOLD.
REQ-016 IDLE: FIFO not empty -> WR; else pending read -> RD; else stay.
REQ-017 WR: cyc/stb/we high with FIFO head; on wb_ack_i or wb_err_i, pop; then FIFO not empty -> WR (back-to-back, cyc stays high), else IDLE.
REQ-018 RD: cyc/stb high, we low; on wb_ack_i, capture wb_dat_i into am_data_o and go to RD_HOLD; on wb_err_i, load am_data_o with all ones and go to RD_HOLD.
REQ-019 RD_HOLD: am_data_oe high, am_wait_n high; leave to IDLE when synchronized am_oe_n or am_cs_n goes high, dropping am_data_oe in the same cycle.
REQ-020 Each wb_err_i SHALL increment err_cnt_o, saturating at 255.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; FIFO pointers SHALL wrap modulo WF_DEPTH.
REQ-022 SHALL not respond to wb_ack_i or wb_err_i when wb_stb_o is low.

Reset
REQ-023 On wb_rst_i high at a clock edge, the block SHALL set: state IDLE, FIFO empty, cyc/stb/we low, am_data_oe low, am_wait_n high, am_data_o 0, wr_ovf_o 0, err_cnt_o 0, synchronizer flops to idle (cs_n/we_n/oe_n = 1).
REQ-024 Reset mid-transaction SHALL abort it: cyc/stb drop the following cycle, and queued writes are discarded.

Verification
REQ-025 Single write to 0x83000000, data 0xabbabeef, be_n 4'b0000 -> one WB write: adr 0x83000000, dat 0xabbabeef, sel 4'b1111, we 1.
REQ-026 Read of 0x83000000 with slave returning 0xabbabeef -> am_wait_n low until ack, then am_data_o = 0xabbabeef with am_data_oe high until oe_n rises.
REQ-027 Three writes to 0x83000000 with 0xabbabeef, 0x55555555, 0xaaaaaaaa, and ack held off -> three WB writes issued in order, cyc held high between them, am_wait_n low at occupancy 3.
REQ-028 Write then immediate read with slave ack delayed by 5 cycles -> the WB write completes before the WB read starts.
REQ-029 WF_DEPTH+1 writes with no ack and am_wait_n ignored -> wr_ovf_o = 1, exactly WF_DEPTH writes later appear on WB.
REQ-030 wb_err_i on a read -> am_data_o = 0xffffffff and err_cnt_o = 1; wb_rst_i asserted during WR -> cyc low next cycle and all outputs at their REQ-023 values.
